// File: rtl/div_32_bit_seq_pkg.sv
// Shared definitions for the sequential 32-bit divider: FSM state encoding,
// default widths and the divide-by-zero quotient.
package div_32_bit_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_32_bit_seq_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_32_bit_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // The shifted remainder needs WIDTH+1 bits once the divisor exceeds 2^(WIDTH-1);
  // when it fits, the difference is always below the divisor so WIDTH bits suffice.
  assign w_shift = {i_rem, i_bit};
  assign o_qbit  = (w_shift >= {1'b0, i_div});
  assign w_diff  = w_shift[WIDTH-1:0] - i_div;
  assign o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_32_bit_seq.sv
// Multi-cycle restoring divider producing quotient (LO) and remainder (HI).
// Define DIV_SIGNED_EN to honour i_is_signed (DIV); otherwise every op is DIVU.
//
// state   | meaning
// IDLE    | waiting for i_start; results held
// RUN     | one restoring step per cycle, WIDTH cycles
// FIX     | sign fix-up of quotient/remainder, register results
// DONE    | o_done pulse, back to IDLE
module div_32_bit_seq
  import div_32_bit_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_qbit;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_dvd_neg;
  logic w_dvs_neg;

  assign w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
  assign w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
  assign w_dvs_mag = w_dvs_neg ? -i_divisor : i_divisor;
`else
  logic w_unused_sign;

  assign w_unused_sign = i_is_signed;
  assign w_dvd_mag     = i_dividend;
  assign w_dvs_mag     = i_divisor;
`endif

  div_32_bit_seq_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_div  (r_d),
    .i_bit  (r_q[WIDTH-1]),
    .o_rem  (w_step_rem),
    .o_qbit (w_step_qbit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_div_zero  <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            if (i_divisor == '0) begin
              o_quotient  <= DIV_ZERO_Q[WIDTH-1:0];
              o_remainder <= i_dividend;
              o_div_zero  <= 1'b1;
              o_done      <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_rem   <= '0;
              r_q     <= w_dvd_mag;
              r_d     <= w_dvs_mag;
              r_cnt   <= '0;
              o_busy  <= 1'b1;
              r_state <= ST_RUN;
`ifdef DIV_SIGNED_EN
              r_neg_q <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r <= w_dvd_neg;
`endif
            end
          end
        end
        ST_RUN: begin
          r_rem <= w_step_rem;
          r_q   <= {r_q[WIDTH-2:0], w_step_qbit};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          // Quotient negation wraps, so 0x8000_0000 / -1 yields 0x8000_0000.
`ifdef DIV_SIGNED_EN
          o_quotient  <= r_neg_q ? -r_q : r_q;
          o_remainder <= r_neg_r ? -r_rem : r_rem;
`else
          o_quotient  <= r_q;
          o_remainder <= r_rem;
`endif
          o_div_zero  <= 1'b0;
          o_done      <= 1'b1;
          o_busy      <= 1'b0;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          o_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_32_bit_seq.sv
// Self-checking bench for div_32_bit_seq: directed scenarios plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_div_32_bit_seq;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  div_32_bit_seq dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_is_signed (is_signed),
    .i_dividend  (dividend),
    .i_divisor   (divisor),
    .o_busy      (busy),
    .o_done      (done),
    .o_quotient  (quotient),
    .o_remainder (remainder),
    .o_div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: MIPS DIV/DIVU semantics with truncating division.
  function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    z = (b == 32'd0);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Drives one op; returns cycles from start to done and count of busy-protocol violations.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_err);
    @(negedge clk);
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat      = 1;
    busy_err = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_err++;
      @(negedge clk);
      lat++;
    end
    if (busy) busy_err++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/dz=%b required 000", {busy, done, div_zero});
    end
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_results: got q=%h r=%h required 0/0", quotient, remainder);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int lat, berr;
    run_op(1'b0, 32'd100, 32'd7, lat, berr);
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL divu_latency: got %0d required 34", lat); end
    checks++;
    if (berr !== 0) begin errors++; $display("FAIL divu_busy: got %0d violations required 0", berr); end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL divu_result: got q=%0d r=%0d dz=%b required 14/2/0", quotient, remainder, div_zero);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL divu_hold: got q=%0d r=%0d done=%b required 14/2/0", quotient, remainder, done);
    end
  endtask

  task automatic test_div_signed();
    int lat, berr;
    logic [31:0] eq, er;
    logic ez;
    model(1'b1, -32'sd100, 32'd7, eq, er, ez);
    run_op(1'b1, -32'sd100, 32'd7, lat, berr);
    checks++;
    if (quotient !== eq || remainder !== er || div_zero !== ez) begin
      errors++;
      $display("FAIL div_signed: got q=%h r=%h dz=%b required %h/%h/%b", quotient, remainder, div_zero, eq, er, ez);
    end
    checks++;
    if (lat !== 34) begin errors++; $display("FAIL div_signed_latency: got %0d required 34", lat); end
  endtask

  task automatic test_div_zero();
    int lat, berr;
    run_op(1'b0, 32'h1234, 32'd0, lat, berr);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL divzero_latency: got %0d required 1", lat); end
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234 || div_zero !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL divzero_result: got q=%h r=%h dz=%b busy=%b required ffffffff/1234/1/0",
               quotient, remainder, div_zero, busy);
    end
  endtask

  task automatic test_overflow();
    int lat, berr;
    logic [31:0] eq, er;
    logic ez;
    model(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, eq, er, ez);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, berr);
    checks++;
    if (quotient !== eq || remainder !== er || div_zero !== ez || lat !== 34) begin
      errors++;
      $display("FAIL overflow: got q=%h r=%h dz=%b lat=%0d required %h/%h/%b/34",
               quotient, remainder, div_zero, lat, eq, er, ez);
    end
  endtask

  task automatic test_ignored_start();
    int ndone, dcyc;
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    ndone = 0;
    dcyc  = -1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (done) begin ndone++; dcyc = c; end
      start = (c == 5 || c == 34);
      if (start) begin
        dividend = 32'd50;
        divisor  = 32'd5;
      end
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || dcyc !== 34) begin
      errors++;
      $display("FAIL ignored_start_done: got %0d pulses at cycle %0d required 1 at 34", ndone, dcyc);
    end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++;
      $display("FAIL ignored_start_result: got q=%0d r=%0d required 14/2", quotient, remainder);
    end
  endtask

  task automatic test_reset_mid();
    int ndone, lat, berr;
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy/done/dz=%b q=%h r=%h required all 0",
               {busy, done, div_zero}, quotient, remainder);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL reset_mid_abort: got %0d busy/done cycles required 0", ndone);
    end
    run_op(1'b0, 32'd9, 32'd3, lat, berr);
    checks++;
    if (quotient !== 32'd3 || remainder !== 32'd0 || lat !== 34 || berr !== 0) begin
      errors++;
      $display("FAIL reset_mid_restart: got q=%0d r=%0d lat=%0d busyerr=%0d required 3/0/34/0",
               quotient, remainder, lat, berr);
    end
  endtask

  task automatic test_random();
    int lat, berr, want_lat;
    logic [31:0] a, b, eq, er;
    logic s, ez;
    for (int n = 0; n < 40; n++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = $urandom;
        3: b = $urandom >> 16;
        default: b = -32'($urandom_range(1, 20));
      endcase
      if (n == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (n == 9) begin a = 32'hFFFF_FFFF; b = 32'h8000_0001; end
      model(s, a, b, eq, er, ez);
      want_lat = ez ? 1 : 34;
      run_op(s, a, b, lat, berr);
      checks++;
      if (quotient !== eq || remainder !== er || div_zero !== ez) begin
        errors++;
        $display("FAIL random_result[%0d] s=%b %h/%h: got q=%h r=%h dz=%b required %h/%h/%b",
                 n, s, a, b, quotient, remainder, div_zero, eq, er, ez);
      end
      checks++;
      if (lat !== want_lat || berr !== 0) begin
        errors++;
        $display("FAIL random_timing[%0d]: got lat=%0d busyerr=%0d required %0d/0", n, lat, berr, want_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, berr;
    run_op(1'b0, 32'hFFFF_FFFF, 32'd16, lat1, berr);
    checks++;
    if (quotient !== 32'h0FFF_FFFF || remainder !== 32'd15) begin
      errors++;
      $display("FAIL b2b_first: got q=%h r=%h required 0fffffff/f", quotient, remainder);
    end
    run_op(1'b0, 32'd5, 32'd9, lat2, berr);
    checks++;
    if (quotient !== 32'd0 || remainder !== 32'd5 || lat2 !== 34) begin
      errors++;
      $display("FAIL b2b_second: got q=%h r=%h lat=%0d required 0/5/34", quotient, remainder, lat2);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_div_zero();
    test_overflow();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
